// File: rtl/bus_to_uart_tx_if.sv
// Frame-in / UART-out signal bundle between the sample packer and the UART framer.
// The master side drives the frame, the slave side returns line and status signals.
interface bus_to_uart_tx_if;
  logic        set1;
  logic [63:0] bus_in;
  logic        tx;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic [7:0]  drop_cnt;

  modport master (
    output set1, bus_in,
    input  tx, busy, frame_done, overrun, drop_cnt
  );

  modport slave (
    input  set1, bus_in,
    output tx, busy, frame_done, overrun, drop_cnt
  );
endinterface

// File: rtl/bus_to_uart_tx.sv
// Captures each completed 64-bit sample frame and transmits it as 8N1 UART bytes,
// sample 1 first, with an optional sync-byte header. All logic on fastclk.
module bus_to_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          SYNC_EN      = 1'b1,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input logic             fastclk,
  input logic             reset,
  bus_to_uart_tx_if.slave bus
);

  localparam int unsigned NUM_BYTES = 8 + (SYNC_EN ? 1 : 0);
  localparam logic [11:0] BAUD_MAX  = 12'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BYTE = 4'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e      state_q;
  logic [11:0] baud_q;
  logic [2:0]  bit_idx_q;
  logic [3:0]  byte_idx_q;
  logic [63:0] shadow_q;
  logic        s1_q, s2_q, s3_q;
  logic        tx_q;
  logic        busy_q;
  logic        frame_done_q;
  logic        overrun_q;
  logic [7:0]  drop_cnt_q;

  logic        new_frame;
  logic        baud_end;
  logic [2:0]  bit_idx_d;
  logic [2:0]  data_idx;
  logic [7:0]  cur_byte;
  logic [7:0]  drop_cnt_d;

  // s3 lags s2 by one cycle so a held-high set1 yields exactly one frame.
  assign new_frame = s2_q & ~s3_q;
  assign baud_end  = (baud_q == BAUD_MAX);
  assign bit_idx_d = bit_idx_q + 3'd1;

  always_comb begin
    data_idx   = 3'(byte_idx_q - 4'(SYNC_EN));
    cur_byte   = shadow_q[data_idx*8 +: 8];
    if (SYNC_EN && (byte_idx_q == 4'd0)) begin
      cur_byte = SYNC_BYTE;
    end
    drop_cnt_d = (drop_cnt_q == 8'hFF) ? drop_cnt_q : drop_cnt_q + 8'd1;
  end

  // NOTE: shadow_q is deliberately left out of the reset branch; it is only read
  // after a capture has loaded it, so resetting 64 data flops buys nothing.
  always_ff @(posedge fastclk) begin
    if (reset) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      s1_q         <= bus.set1;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      frame_done_q <= 1'b0;
      overrun_q    <= new_frame & busy_q;
      if (new_frame && busy_q) begin
        drop_cnt_q <= drop_cnt_d;
      end
      // busy stays high through the frame_done cycle, so a frame landing there is dropped.
      if (frame_done_q) begin
        busy_q <= 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (new_frame && !busy_q) begin
            shadow_q   <= bus.bus_in;
            byte_idx_q <= '0;
            baud_q     <= '0;
            busy_q     <= 1'b1;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + 12'd1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_d;
              tx_q      <= cur_byte[bit_idx_d];
            end
          end else begin
            baud_q <= baud_q + 12'd1;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (byte_idx_q == LAST_BYTE) begin
              frame_done_q <= 1'b1;
              state_q      <= IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + 4'd1;
              tx_q       <= 1'b0;
              state_q    <= START;
            end
          end else begin
            baud_q <= baud_q + 12'd1;
          end
        end

        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.overrun    = overrun_q;
  assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_bus_to_uart_tx.sv
// Bench for bus_to_uart_tx: one instance with the sync header, one without, a UART
// decoder per line feeding byte scoreboards, and per-frame timing/status checks.
module tb_bus_to_uart_tx;

  localparam int CPB = 4;

  logic        fastclk = 1'b0;
  logic        reset;
  logic        set1;
  logic [63:0] bus_in;

  always #5 fastclk = ~fastclk;

  bus_to_uart_tx_if if_s ();
  bus_to_uart_tx_if if_n ();

  assign if_s.set1   = set1;
  assign if_s.bus_in = bus_in;
  assign if_n.set1   = set1;
  assign if_n.bus_in = bus_in;

  bus_to_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_EN(1'b1), .SYNC_BYTE(8'hA5)) dut_s (
    .fastclk (fastclk),
    .reset   (reset),
    .bus     (if_s)
  );

  bus_to_uart_tx #(.CLKS_PER_BIT(CPB), .SYNC_EN(1'b0), .SYNC_BYTE(8'hA5)) dut_n (
    .fastclk (fastclk),
    .reset   (reset),
    .bus     (if_n)
  );

  typedef struct {
    logic [63:0] bus;
    logic [7:0]  exp [8];
    int          n_ovr;
  } vec_t;

  vec_t       vecs [5];
  int         vec_cnt  = 0;
  int         err_cnt  = 0;
  int         exp_drop = 0;
  logic [7:0] exp_s [$];
  logic [7:0] exp_n [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART decoders: index 0 watches the sync instance, index 1 the plain one.
  logic       d_act  [2] = '{1'b0, 1'b0};
  logic       d_prev [2] = '{1'b1, 1'b1};
  int         d_cnt  [2];
  logic [7:0] d_byte [2];

  always @(negedge fastclk) begin
    for (int i = 0; i < 2; i++) begin
      logic txb;
      int   k;
      txb = (i == 0) ? if_s.tx : if_n.tx;
      if (reset === 1'b1) begin
        d_act[i] = 1'b0;
      end else if (!d_act[i]) begin
        if (txb === 1'b0 && d_prev[i] === 1'b1) begin
          d_act[i] = 1'b1;
          d_cnt[i] = 0;
        end
      end else begin
        d_cnt[i]++;
        if (d_cnt[i] % CPB == CPB / 2) begin
          k = d_cnt[i] / CPB;
          if (k == 0) begin
            check("start bit level", 64'(txb), 64'd0);
          end else if (k <= 8) begin
            d_byte[i][k-1] = txb;
          end else begin
            check("stop bit level", 64'(txb), 64'd1);
            if (i == 0) begin
              if (exp_s.size() == 0) check("stray byte sync line", 64'(d_byte[i]), 64'h100);
              else check("byte sync line", 64'(d_byte[i]), 64'(exp_s.pop_front()));
            end else begin
              if (exp_n.size() == 0) check("stray byte plain line", 64'(d_byte[i]), 64'h100);
              else check("byte plain line", 64'(d_byte[i]), 64'(exp_n.pop_front()));
            end
            d_act[i] = 1'b0;
          end
        end
      end
      d_prev[i] = txb;
    end
  end

  task automatic wait_idle();
    for (int w = 0; w < 1000 && (if_s.busy !== 1'b0 || if_n.busy !== 1'b0); w++)
      @(negedge fastclk);
    check("idle before frame", {if_s.busy, if_n.busy}, 64'd0);
  endtask

  // One frame: raise set1, optionally fire n_ovr extra edges mid-frame, then audit timing.
  task automatic run_frame(input logic [63:0] b, input logic [7:0] e [8], input int n_ovr);
    int t_start [2];
    int t_done  [2];
    int n_busy  [2];
    int n_fd    [2];
    int n_ov    [2];
    wait_idle();
    bus_in = b;
    exp_s.push_back(8'hA5);
    for (int j = 0; j < 8; j++) begin
      exp_s.push_back(e[j]);
      exp_n.push_back(e[j]);
    end
    for (int i = 0; i < 2; i++) begin
      t_start[i] = -1; t_done[i] = -1; n_busy[i] = 0; n_fd[i] = 0; n_ov[i] = 0;
    end
    exp_drop = (exp_drop + n_ovr > 255) ? 255 : exp_drop + n_ovr;
    set1 = 1'b1;
    for (int c = 1; c <= 400; c++) begin
      @(negedge fastclk);
      for (int i = 0; i < 2; i++) begin
        logic txb, bsy, fd, ov;
        txb = (i == 0) ? if_s.tx         : if_n.tx;
        bsy = (i == 0) ? if_s.busy       : if_n.busy;
        fd  = (i == 0) ? if_s.frame_done : if_n.frame_done;
        ov  = (i == 0) ? if_s.overrun    : if_n.overrun;
        if (t_start[i] < 0 && txb === 1'b0) t_start[i] = c;
        if (bsy === 1'b1) n_busy[i]++;
        if (fd === 1'b1) begin n_fd[i]++; t_done[i] = c; end
        if (ov === 1'b1) n_ov[i]++;
      end
      if (n_ovr == 0) begin
        if (c == 50) set1 = 1'b0;
      end else begin
        if (c >= 10 && c < 10 + 6 * n_ovr) begin
          if ((c - 10) % 6 == 0) set1 = 1'b0;
          else if ((c - 10) % 6 == 3) begin set1 = 1'b1; bus_in = ~b; end
        end
        if (c == 10 + 6 * n_ovr) set1 = 1'b0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      int nb;
      nb = (i == 0) ? 9 : 8;
      check(i == 0 ? "start latency sync" : "start latency plain", 64'(t_start[i]), 64'd3);
      check(i == 0 ? "frame length sync" : "frame length plain",
            64'(t_done[i] - t_start[i]), 64'(nb * 10 * CPB));
      check(i == 0 ? "busy cycles sync" : "busy cycles plain", 64'(n_busy[i]), 64'(nb * 10 * CPB + 1));
      check(i == 0 ? "frame_done pulses sync" : "frame_done pulses plain", 64'(n_fd[i]), 64'd1);
      check(i == 0 ? "overrun pulses sync" : "overrun pulses plain", 64'(n_ov[i]), 64'(n_ovr));
    end
    check("drop_cnt sync", 64'(if_s.drop_cnt), 64'(exp_drop));
    check("drop_cnt plain", 64'(if_n.drop_cnt), 64'(exp_drop));
    check("bytes outstanding sync", 64'(exp_s.size()), 64'd0);
    check("bytes outstanding plain", 64'(exp_n.size()), 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h0807_0605_0403_0201, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 0};
    vecs[1] = '{64'hFFFF_0000_AAAA_5555, '{8'h55, 8'h55, 8'hAA, 8'hAA, 8'h00, 8'h00, 8'hFF, 8'hFF}, 0};
    vecs[2] = '{64'h0123_4567_89AB_CDEF, '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01}, 1};
    vecs[3] = '{64'h8000_0000_0000_0001, '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}, 0};
    vecs[4] = '{64'hDEAD_BEEF_CAFE_F00D, '{8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 0};

    // Reset held five cycles with set1 low: line idle, no status activity.
    reset  = 1'b1;
    set1   = 1'b0;
    bus_in = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge fastclk);
      check("reset state sync", {if_s.tx, if_s.busy, if_s.frame_done, if_s.overrun, if_s.drop_cnt},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
      check("reset state plain", {if_n.tx, if_n.busy, if_n.frame_done, if_n.overrun, if_n.drop_cnt},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    end
    reset = 1'b0;
    repeat (3) @(negedge fastclk);

    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].bus, vecs[v].exp, vecs[v].n_ovr);
    end

    // Reset in the middle of the third byte, bit 4, with set1 still high.
    wait_idle();
    bus_in = vecs[0].bus;
    for (int j = 0; j < 8; j++) exp_n.push_back(vecs[0].exp[j]);
    exp_s.push_back(8'hA5);
    for (int j = 0; j < 8; j++) exp_s.push_back(vecs[0].exp[j]);
    set1 = 1'b1;
    repeat (104) @(negedge fastclk);
    check("busy before mid-frame reset", {if_s.busy, if_n.busy}, 64'h3);
    reset = 1'b1;
    @(negedge fastclk);
    check("tx/busy after mid-frame reset sync", {if_s.tx, if_s.busy}, 64'h2);
    check("tx/busy after mid-frame reset plain", {if_n.tx, if_n.busy}, 64'h2);
    check("drop_cnt after reset", {if_s.drop_cnt, if_n.drop_cnt}, 64'd0);
    @(negedge fastclk);
    exp_s.delete();
    exp_n.delete();
    exp_drop = 0;
    reset = 1'b0;
    // set1 is still high at release: this is a fresh edge and a full frame follows.
    run_frame(vecs[0].bus, vecs[0].exp, 0);

    // Repeated overruns drive drop_cnt into saturation without disturbing the frames.
    for (int f = 0; f < 7; f++) begin
      run_frame(vecs[4].bus, vecs[4].exp, 40);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
